icache_axi_refill: RTL and testbench

ICACHE_AXI_REFILL -- requirements
Module: icache_axi_refill

---
 rtl/icache_refill_pkg.sv | 35 +++
 rtl/icache_refill_fifo.sv | 84 ++++++++
 rtl/icache_axi_refill.sv | 198 +++++++++++++++++++
 tb/tb_icache_axi_refill.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_refill_pkg.sv
// Shared types and constants for the instruction-cache AXI refill engine.
// Optional error reporting is enabled by defining ICACHE_REFILL_ERR_EN.
package icache_refill_pkg;

    localparam int unsigned LineWidthDflt    = 128;
    localparam int unsigned AxiDataWidthDflt = 64;
    localparam int unsigned BeatsPerLine     = LineWidthDflt / AxiDataWidthDflt;

    localparam int unsigned MaxPaddrWidth = 64;
    localparam int unsigned MaxIdWidth    = 16;

    localparam logic [1:0] INCR   = 2'b01;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RTRN
    } refill_state_e;

    // Sized for the widest supported address/ID; the top zero-extends into it.
    typedef struct packed {
        logic [MaxPaddrWidth-1:0] paddr;
        logic                     nc;
        logic [MaxIdWidth-1:0]    tid;
    } refill_req_t;

    function automatic logic [63:0] addr_mask(input int unsigned off_bits);
        return ~((64'd1 << off_bits) - 64'd1);
    endfunction

endpackage

// File: rtl/icache_refill_fifo.sv
// Request queue for the refill engine: power-of-two depth, generic entry type,
// same-cycle flush that also discards a concurrent push.
module icache_refill_fifo #(
    parameter int unsigned Depth = 2,
    parameter type         T     = logic
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic flush_i,
    input  logic push_i,
    input  T     data_i,
    input  logic pop_i,
    output T     data_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    T                mem_q [Depth];
    logic            do_push;
    logic            do_pop;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        if (p == PtrW'(Depth - 1)) begin
            return '0;
        end
        return p + PtrW'(1);
    endfunction

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign data_o  = mem_q[rd_ptr_q];

    // No pass-through: a full queue refuses a push even if it pops this cycle.
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = next_ptr(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
            end
            if (do_push && !do_pop) begin
                cnt_d = cnt_q + CntW'(1);
            end else if (!do_push && do_pop) begin
                cnt_d = cnt_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/icache_axi_refill.sv
// Instruction-cache line refill over a single-outstanding AXI read channel.
// Define ICACHE_REFILL_ERR_EN to report R-channel errors on rtrn_err_o.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for a queued request; head copied into AR registers
// ST_ADDR | ar_valid_o held with stable fields until ar_ready_i; pops head
// ST_DATA | r_ready_o high, beats assembled into the line buffer
// ST_RTRN | one-cycle line return (no backpressure)
import icache_refill_pkg::*;

module icache_axi_refill #(
    parameter int unsigned LineWidth    = 128,
    parameter int unsigned AxiDataWidth = 64,
    parameter int unsigned AxiIdWidth   = 4,
    parameter int unsigned PlenWidth    = 56,
    parameter int unsigned ReqDepth     = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [PlenWidth-1:0]    req_paddr_i,
    input  logic                    req_nc_i,
    input  logic [AxiIdWidth-1:0]   req_tid_i,
    output logic                    rtrn_valid_o,
    output logic [LineWidth-1:0]    rtrn_data_o,
    output logic [AxiIdWidth-1:0]   rtrn_tid_o,
    output logic                    rtrn_err_o,
    output logic                    ar_valid_o,
    input  logic                    ar_ready_i,
    output logic [63:0]             ar_addr_o,
    output logic [7:0]              ar_len_o,
    output logic [2:0]              ar_size_o,
    output logic [1:0]              ar_burst_o,
    output logic [AxiIdWidth-1:0]   ar_id_o,
    input  logic                    r_valid_i,
    output logic                    r_ready_o,
    input  logic [AxiDataWidth-1:0] r_data_i,
    input  logic [1:0]              r_resp_i,
    input  logic                    r_last_i,
    input  logic [AxiIdWidth-1:0]   r_id_i
);

    localparam int unsigned NumBeats = LineWidth / AxiDataWidth;
    localparam int unsigned BeatCntW = $clog2(NumBeats + 1);
    localparam logic [63:0] LineMask = addr_mask($clog2(LineWidth / 8));
    localparam logic [63:0] BeatMask = addr_mask($clog2(AxiDataWidth / 8));

    refill_state_e         state_q, state_d;
    logic [63:0]           ar_addr_q, ar_addr_d;
    logic [7:0]            ar_len_q, ar_len_d;
    logic [AxiIdWidth-1:0] ar_id_q, ar_id_d;
    logic [BeatCntW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [LineWidth-1:0]  line_q, line_d;
    logic                  err_q, err_d;
    logic                  flush_sup_q, flush_sup_d;

    refill_req_t           req_entry;
    refill_req_t           head;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  unused_ok;

    assign req_entry.paddr = MaxPaddrWidth'(req_paddr_i);
    assign req_entry.nc    = req_nc_i;
    assign req_entry.tid   = MaxIdWidth'(req_tid_i);

    assign req_ready_o = !fifo_full && !rst_i;
    assign fifo_push   = req_valid_i && req_ready_o;

    icache_refill_fifo #(
        .Depth (ReqDepth),
        .T     (refill_req_t)
    ) u_req_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (fifo_push),
        .data_i  (req_entry),
        .pop_i   (fifo_pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        ar_addr_d   = ar_addr_q;
        ar_len_d    = ar_len_q;
        ar_id_d     = ar_id_q;
        beat_cnt_d  = beat_cnt_q;
        line_d      = line_q;
        err_d       = err_q;
        flush_sup_d = flush_sup_q;
        fifo_pop    = 1'b0;
        ar_valid_o  = 1'b0;
        r_ready_o   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // The head stays queued until its AR handshake frees the slot.
                if (!fifo_empty && !flush_i) begin
                    ar_addr_d = head.nc ? (head.paddr & BeatMask) : (head.paddr & LineMask);
                    ar_len_d  = head.nc ? 8'd0 : 8'(NumBeats - 1);
                    ar_id_d   = head.tid[AxiIdWidth-1:0];
                    state_d   = ST_ADDR;
                end
            end
            ST_ADDR: begin
                ar_valid_o = 1'b1;
                if (flush_i) begin
                    flush_sup_d = 1'b1;
                end
                if (ar_ready_i) begin
                    fifo_pop   = 1'b1;
                    beat_cnt_d = '0;
                    line_d     = '0;
                    err_d      = 1'b0;
                    state_d    = ST_DATA;
                end
            end
            ST_DATA: begin
                r_ready_o = 1'b1;
                if (flush_i) begin
                    flush_sup_d = 1'b1;
                end
                if (r_valid_i) begin
                    for (int unsigned k = 0; k < NumBeats; k++) begin
                        if (beat_cnt_q == BeatCntW'(k)) begin
                            line_d[k*AxiDataWidth +: AxiDataWidth] = r_data_i;
                        end
                    end
                    if (beat_cnt_q != BeatCntW'(NumBeats)) begin
                        beat_cnt_d = beat_cnt_q + BeatCntW'(1);
                    end
`ifdef ICACHE_REFILL_ERR_EN
                    err_d = err_q | r_resp_i[1];
`endif
                    if (r_last_i) begin
                        flush_sup_d = 1'b0;
                        state_d     = (flush_sup_q || flush_i) ? ST_IDLE : ST_RTRN;
                    end
                end
            end
            ST_RTRN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            ar_addr_q   <= '0;
            ar_len_q    <= '0;
            ar_id_q     <= '0;
            beat_cnt_q  <= '0;
            line_q      <= '0;
            err_q       <= 1'b0;
            flush_sup_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ar_addr_q   <= ar_addr_d;
            ar_len_q    <= ar_len_d;
            ar_id_q     <= ar_id_d;
            beat_cnt_q  <= beat_cnt_d;
            line_q      <= line_d;
            err_q       <= err_d;
            flush_sup_q <= flush_sup_d;
        end
    end

    assign ar_addr_o  = ar_addr_q;
    assign ar_len_o   = ar_len_q;
    assign ar_size_o  = 3'($clog2(AxiDataWidth / 8));
    assign ar_burst_o = INCR;
    assign ar_id_o    = ar_id_q;

    assign rtrn_valid_o = (state_q == ST_RTRN);
    assign rtrn_tid_o   = rtrn_valid_o ? ar_id_q : '0;
    // err_q never sets without error reporting, so data passes unchanged then.
    assign rtrn_data_o  = (rtrn_valid_o && !err_q) ? line_q : '0;
`ifdef ICACHE_REFILL_ERR_EN
    assign rtrn_err_o   = rtrn_valid_o && err_q;
`else
    assign rtrn_err_o   = 1'b0;
`endif

    assign unused_ok = ^{r_id_i, r_resp_i, head.tid};

endmodule

// File: tb/tb_icache_axi_refill.sv
// Directed self-checking bench: a Line=128/Data=32 instance for the main
// sequences and a Line=128/Data=64 instance for the non-cacheable case.
import icache_refill_pkg::*;

module tb_icache_axi_refill;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    // instance A: Data=32
    logic         a_flush, a_req_valid, a_req_ready, a_req_nc;
    logic [55:0]  a_req_paddr;
    logic [3:0]   a_req_tid, a_rtrn_tid, a_ar_id, a_r_id;
    logic         a_rtrn_valid, a_rtrn_err, a_ar_valid, a_ar_ready;
    logic [127:0] a_rtrn_data;
    logic [63:0]  a_ar_addr;
    logic [7:0]   a_ar_len;
    logic [2:0]   a_ar_size;
    logic [1:0]   a_ar_burst, a_r_resp;
    logic         a_r_valid, a_r_ready, a_r_last;
    logic [31:0]  a_r_data;

    // instance B: Data=64
    logic         b_flush, b_req_valid, b_req_ready, b_req_nc;
    logic [55:0]  b_req_paddr;
    logic [3:0]   b_req_tid, b_rtrn_tid, b_ar_id, b_r_id;
    logic         b_rtrn_valid, b_rtrn_err, b_ar_valid, b_ar_ready;
    logic [127:0] b_rtrn_data;
    logic [63:0]  b_ar_addr;
    logic [7:0]   b_ar_len;
    logic [2:0]   b_ar_size;
    logic [1:0]   b_ar_burst, b_r_resp;
    logic         b_r_valid, b_r_ready, b_r_last;
    logic [63:0]  b_r_data;

    icache_axi_refill #(
        .LineWidth(128), .AxiDataWidth(32), .AxiIdWidth(4), .PlenWidth(56), .ReqDepth(2)
    ) u_dut_a (
        .clk_i(clk), .rst_i(rst), .flush_i(a_flush),
        .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_paddr_i(a_req_paddr),
        .req_nc_i(a_req_nc), .req_tid_i(a_req_tid),
        .rtrn_valid_o(a_rtrn_valid), .rtrn_data_o(a_rtrn_data), .rtrn_tid_o(a_rtrn_tid),
        .rtrn_err_o(a_rtrn_err),
        .ar_valid_o(a_ar_valid), .ar_ready_i(a_ar_ready), .ar_addr_o(a_ar_addr),
        .ar_len_o(a_ar_len), .ar_size_o(a_ar_size), .ar_burst_o(a_ar_burst), .ar_id_o(a_ar_id),
        .r_valid_i(a_r_valid), .r_ready_o(a_r_ready), .r_data_i(a_r_data),
        .r_resp_i(a_r_resp), .r_last_i(a_r_last), .r_id_i(a_r_id)
    );

    icache_axi_refill #(
        .LineWidth(128), .AxiDataWidth(64), .AxiIdWidth(4), .PlenWidth(56), .ReqDepth(2)
    ) u_dut_b (
        .clk_i(clk), .rst_i(rst), .flush_i(b_flush),
        .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_paddr_i(b_req_paddr),
        .req_nc_i(b_req_nc), .req_tid_i(b_req_tid),
        .rtrn_valid_o(b_rtrn_valid), .rtrn_data_o(b_rtrn_data), .rtrn_tid_o(b_rtrn_tid),
        .rtrn_err_o(b_rtrn_err),
        .ar_valid_o(b_ar_valid), .ar_ready_i(b_ar_ready), .ar_addr_o(b_ar_addr),
        .ar_len_o(b_ar_len), .ar_size_o(b_ar_size), .ar_burst_o(b_ar_burst), .ar_id_o(b_ar_id),
        .r_valid_i(b_r_valid), .r_ready_o(b_r_ready), .r_data_i(b_r_data),
        .r_resp_i(b_r_resp), .r_last_i(b_r_last), .r_id_i(b_r_id)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] exp_line(input int n, input logic [31:0] base);
        logic [127:0] l;
        l = '0;
        for (int k = 0; k < n; k++) begin
            l[k*32 +: 32] = base + 32'(k);
        end
        return l;
    endfunction

    // All A-side tasks start and end on a negedge.
    task automatic push_req(input logic [55:0] paddr, input logic nc, input logic [3:0] tid);
        bit ok;
        ok          = 1'b0;
        a_req_valid = 1'b1;
        a_req_paddr = paddr;
        a_req_nc    = nc;
        a_req_tid   = tid;
        for (int i = 0; i < 60; i++) begin
            if (a_req_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("req_timeout", 1'b0, 1'b1);
        @(negedge clk);
        a_req_valid = 1'b0;
    endtask

    task automatic wait_ar(input logic [63:0] addr, input logic [7:0] len, input logic [3:0] id);
        for (int i = 0; i < 60; i++) begin
            if (a_ar_valid) break;
            @(negedge clk);
        end
        if (!a_ar_valid) begin
            check("ar_timeout", 1'b0, 1'b1);
            return;
        end
        check("ar_addr", a_ar_addr, addr);
        check("ar_len", a_ar_len, len);
        check("ar_size", a_ar_size, 3'd2);
        check("ar_burst", a_ar_burst, 2'b01);
        check("ar_id", a_ar_id, id);
        a_ar_ready = 1'b1;
        @(negedge clk);
        a_ar_ready = 1'b0;
        check("ar_valid_drop", a_ar_valid, 1'b0);
    endtask

    task automatic send_beats(input int n, input logic [31:0] base, input int err_beat,
                              input int flush_beat);
        for (int k = 0; k < n; k++) begin
            a_r_valid = 1'b1;
            a_r_data  = base + 32'(k);
            a_r_last  = (k == n - 1);
            a_r_resp  = (k == err_beat) ? SLVERR : OKAY;
            a_flush   = (k == flush_beat);
            check("r_ready", a_r_ready, 1'b1);
            @(negedge clk);
        end
        a_r_valid = 1'b0;
        a_r_last  = 1'b0;
        a_r_resp  = OKAY;
        a_flush   = 1'b0;
    endtask

    task automatic check_rtrn(input string tag, input logic [127:0] data, input logic [3:0] tid,
                              input logic err);
        check({tag, "_valid"}, a_rtrn_valid, 1'b1);
        check({tag, "_data"}, a_rtrn_data, data);
        check({tag, "_tid"}, a_rtrn_tid, tid);
        check({tag, "_err"}, a_rtrn_err, err);
        @(negedge clk);
        check({tag, "_one_cycle"}, a_rtrn_valid, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        a_flush = 0; a_req_valid = 0; a_req_paddr = '0; a_req_nc = 0; a_req_tid = '0;
        a_ar_ready = 0; a_r_valid = 0; a_r_data = '0; a_r_resp = '0; a_r_last = 0; a_r_id = '0;
        b_flush = 0; b_req_valid = 0; b_req_paddr = '0; b_req_nc = 0; b_req_tid = '0;
        b_ar_ready = 0; b_r_valid = 0; b_r_data = '0; b_r_resp = '0; b_r_last = 0; b_r_id = '0;

        repeat (3) @(negedge clk);
        check("rst_req_ready_a", a_req_ready, 1'b0);
        check("rst_req_ready_b", b_req_ready, 1'b0);
        rst = 1'b0;
        #1;
        check("post_rst_req_ready", a_req_ready, 1'b1);
        check("post_rst_ar_valid", a_ar_valid, 1'b0);
        check("post_rst_r_ready", a_r_ready, 1'b0);
        check("post_rst_rtrn_valid", a_rtrn_valid, 1'b0);
        check("post_rst_rtrn_data", a_rtrn_data, 128'h0);
        check("post_rst_rtrn_tid", a_rtrn_tid, 4'h0);
        check("post_rst_rtrn_err", a_rtrn_err, 1'b0);
        @(negedge clk);

        // cacheable line, 4 x 32-bit beats
        push_req(56'h8000_1234, 1'b0, 4'd3);
        wait_ar(64'h8000_1230, 8'd3, 4'd3);
        send_beats(4, 32'hA, -1, -1);
        check_rtrn("t1", 128'h0000000D_0000000C_0000000B_0000000A, 4'd3, 1'b0);

        // three back-to-back requests, AR stalled: third waits for a free slot
        push_req(56'h100, 1'b0, 4'd1);
        push_req(56'h204, 1'b0, 4'd2);
        fork
            push_req(56'h30E, 1'b1, 4'd3);
            begin
                check("stall_ready", a_req_ready, 1'b0);
                repeat (3) begin
                    @(negedge clk);
                    check("stall_ready", a_req_ready, 1'b0);
                    check("stall_ar_valid", a_ar_valid, 1'b1);
                    check("stall_ar_addr", a_ar_addr, 64'h100);
                end
                wait_ar(64'h100, 8'd3, 4'd1);
                send_beats(4, 32'h10, -1, -1);
                check_rtrn("q1", exp_line(4, 32'h10), 4'd1, 1'b0);
                wait_ar(64'h200, 8'd3, 4'd2);
                send_beats(4, 32'h20, -1, -1);
                check_rtrn("q2", exp_line(4, 32'h20), 4'd2, 1'b0);
                wait_ar(64'h30C, 8'd0, 4'd3);
                send_beats(1, 32'h30, -1, -1);
                check_rtrn("q3", 128'h30, 4'd3, 1'b0);
            end
        join

        // flush after the 2nd of 4 beats with one request queued
        push_req(56'h400, 1'b0, 4'd4);
        push_req(56'h440, 1'b0, 4'd5);
        wait_ar(64'h400, 8'd3, 4'd4);
        send_beats(4, 32'h40, -1, 2);
        repeat (4) begin
            check("flush_no_rtrn", a_rtrn_valid, 1'b0);
            check("flush_no_ar", a_ar_valid, 1'b0);
            check("flush_ready", a_req_ready, 1'b1);
            @(negedge clk);
        end

        // error on one beat, then a clean fill
        push_req(56'h500, 1'b0, 4'd6);
        wait_ar(64'h500, 8'd3, 4'd6);
        send_beats(4, 32'h50, 1, -1);
`ifdef ICACHE_REFILL_ERR_EN
        check_rtrn("err", 128'h0, 4'd6, 1'b1);
`else
        check_rtrn("err", exp_line(4, 32'h50), 4'd6, 1'b0);
`endif
        push_req(56'h51F, 1'b0, 4'd7);
        wait_ar(64'h510, 8'd3, 4'd7);
        send_beats(4, 32'h60, -1, -1);
        check_rtrn("clean", exp_line(4, 32'h60), 4'd7, 1'b0);

        // early r_last: missing words stay zero
        push_req(56'h800, 1'b0, 4'd10);
        wait_ar(64'h800, 8'd3, 4'd10);
        send_beats(2, 32'h80, -1, -1);
        check_rtrn("short", 128'h00000081_00000080, 4'd10, 1'b0);

        // reset in DATA after one beat
        push_req(56'h600, 1'b0, 4'd8);
        wait_ar(64'h600, 8'd3, 4'd8);
        a_r_valid = 1'b1; a_r_data = 32'h99; a_r_last = 1'b0;
        @(negedge clk);
        a_r_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_req_ready", a_req_ready, 1'b0);
        check("mid_rst_ar_valid", a_ar_valid, 1'b0);
        check("mid_rst_r_ready", a_r_ready, 1'b0);
        check("mid_rst_rtrn_valid", a_rtrn_valid, 1'b0);
        check("mid_rst_rtrn_data", a_rtrn_data, 128'h0);
        check("mid_rst_rtrn_tid", a_rtrn_tid, 4'h0);
        check("mid_rst_rtrn_err", a_rtrn_err, 1'b0);
        rst = 1'b0;
        #1;
        check("after_rst_req_ready", a_req_ready, 1'b1);
        @(negedge clk);
        check("after_rst_ar_idle", a_ar_valid, 1'b0);
        push_req(56'h700, 1'b0, 4'd9);
        wait_ar(64'h700, 8'd3, 4'd9);
        send_beats(4, 32'h70, -1, -1);
        check_rtrn("rst_refill", exp_line(4, 32'h70), 4'd9, 1'b0);

        // non-cacheable on the 64-bit instance
        b_req_valid = 1'b1; b_req_paddr = 56'h1006; b_req_nc = 1'b1; b_req_tid = 4'd5;
        for (int i = 0; i < 20 && !b_req_ready; i++) @(negedge clk);
        @(negedge clk);
        b_req_valid = 1'b0;
        for (int i = 0; i < 20 && !b_ar_valid; i++) @(negedge clk);
        check("nc_ar_valid", b_ar_valid, 1'b1);
        check("nc_ar_addr", b_ar_addr, 64'h1000);
        check("nc_ar_len", b_ar_len, 8'd0);
        check("nc_ar_size", b_ar_size, 3'd3);
        check("nc_ar_id", b_ar_id, 4'd5);
        b_ar_ready = 1'b1;
        @(negedge clk);
        b_ar_ready = 1'b0;
        b_r_valid = 1'b1; b_r_data = 64'h1122334455667788; b_r_last = 1'b1;
        check("nc_r_ready", b_r_ready, 1'b1);
        @(negedge clk);
        b_r_valid = 1'b0; b_r_last = 1'b0;
        check("nc_rtrn_valid", b_rtrn_valid, 1'b1);
        check("nc_rtrn_data", b_rtrn_data, 128'h0000000000000000_1122334455667788);
        check("nc_rtrn_tid", b_rtrn_tid, 4'd5);
        @(negedge clk);
        check("nc_rtrn_one_cycle", b_rtrn_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
